// File: rtl/pipe_pkg.sv
// Shared pipeline package: stall bus encodings used across the pipeline stages.
package pipe_pkg;

  localparam int STALL_W = 2;

  localparam logic [STALL_W-1:0] STALL_PASS = 2'b00;
  localparam logic [STALL_W-1:0] STALL_HOLD = 2'b01;
  localparam logic [STALL_W-1:0] STALL_BUBB = 2'b10;

  // Width of a source index for a given number of sources (never below 1 bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pc_redirect_stage_redir_arbiter.sv
// Fixed-priority redirect arbiter: lowest asserted index wins; target passed through raw.
module redir_arbiter
  import pipe_pkg::*;
#(
  parameter int NUM_REDIR = 3,
  parameter int ADDR_W    = 32,
  localparam int IDX_W    = idx_width(NUM_REDIR)
) (
  input  logic [NUM_REDIR-1:0]        redir_valid_i,
  input  logic [NUM_REDIR*ADDR_W-1:0] redir_pc_i,
  output logic                        hit_o,
  output logic [IDX_W-1:0]            idx_o,
  output logic [ADDR_W-1:0]           target_o
);

  // Scan from lowest priority upward so the lowest asserted index is the last write.
  always_comb begin
    hit_o    = 1'b0;
    idx_o    = '0;
    target_o = '0;
    for (int k = NUM_REDIR - 1; k >= 0; k--) begin
      if (redir_valid_i[k]) begin
        hit_o    = 1'b1;
        idx_o    = IDX_W'(k);
        target_o = redir_pc_i[k*ADDR_W +: ADDR_W];
      end
    end
  end

endmodule

// File: rtl/pc_redirect_stage.sv
// IF-stage fetch PC register: sequential PC, prioritised redirects, stall obedience,
// redirect latching while frozen, and an epoch tag bumped on every applied redirect.
module pc_redirect_stage
  import pipe_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                NUM_REDIR = 3,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int                INC       = 4,
  parameter int                ALIGN_LSB = 2,
  parameter int                EPOCH_W   = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [STALL_W-1:0]          stall,
  input  logic [NUM_REDIR-1:0]        redir_valid_i,
  input  logic [NUM_REDIR*ADDR_W-1:0] redir_pc_i,
  output logic [ADDR_W-1:0]           pc_o,
  output logic                        valid_o,
  output logic [EPOCH_W-1:0]          epoch_o,
  output logic                        pend_valid_o
);

  localparam int IDX_W = idx_width(NUM_REDIR);

  logic [ADDR_W-1:0]  r_pc;
  logic               r_valid;
  logic [EPOCH_W-1:0] r_epoch;
  logic               r_pend_valid;
  logic [IDX_W-1:0]   r_pend_idx;
  logic [ADDR_W-1:0]  r_pend_pc;

  logic               w_arb_hit;
  logic [IDX_W-1:0]   w_arb_idx;
  logic [ADDR_W-1:0]  w_arb_pc;
  logic               w_eff_hit;
  logic [IDX_W-1:0]   w_eff_idx;
  logic [ADDR_W-1:0]  w_eff_pc;

  // Clear the low ALIGN_LSB bits of a redirect target.
  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] m;
    m = '1;
    m = m << ALIGN_LSB;
    return a & m;
  endfunction

  redir_arbiter #(
    .NUM_REDIR (NUM_REDIR),
    .ADDR_W    (ADDR_W)
  ) u_arb (
    .redir_valid_i (redir_valid_i),
    .redir_pc_i    (redir_pc_i),
    .hit_o         (w_arb_hit),
    .idx_o         (w_arb_idx),
    .target_o      (w_arb_pc)
  );

  // Merge latched redirect with this cycle's winner; on equal index the newer one wins.
  always_comb begin
    w_eff_hit = w_arb_hit | r_pend_valid;
    w_eff_idx = w_arb_idx;
    w_eff_pc  = align_pc(w_arb_pc);
    if (r_pend_valid && (!w_arb_hit || (r_pend_idx < w_arb_idx))) begin
      w_eff_idx = r_pend_idx;
      w_eff_pc  = r_pend_pc;
    end
  end

  // PC / valid / epoch / pending update under the stall code.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc         <= RESET_PC;
      r_valid      <= 1'b0;
      r_epoch      <= '0;
      r_pend_valid <= 1'b0;
      r_pend_idx   <= '0;
      r_pend_pc    <= '0;
    end else if (stall == STALL_PASS) begin
      if (w_eff_hit) begin
        r_pc         <= w_eff_pc;
        r_valid      <= 1'b1;
        r_epoch      <= r_epoch + 1'b1;
        r_pend_valid <= 1'b0;
        r_pend_idx   <= '0;
        r_pend_pc    <= '0;
      end else if (!r_valid) begin
        r_valid <= 1'b1;
      end else begin
        r_pc <= r_pc + ADDR_W'(INC);
      end
    end else begin
      // Hold, Bubb and the reserved code all freeze the PC and latch any redirect.
      if (stall == STALL_BUBB) begin
        r_valid <= 1'b0;
      end
      if (w_eff_hit) begin
        r_pend_valid <= 1'b1;
        r_pend_idx   <= w_eff_idx;
        r_pend_pc    <= w_eff_pc;
      end
    end
  end

  assign pc_o         = r_pc;
  assign valid_o      = r_valid;
  assign epoch_o      = r_epoch;
  assign pend_valid_o = r_pend_valid;

endmodule

// File: tb/tb_pc_redirect_stage.sv
// Bench for pc_redirect_stage: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_pc_redirect_stage;

  localparam int ADDR_W = 32;
  localparam int NR     = 3;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [1:0]             stall = 2'b00;
  logic [NR-1:0]          rv = '0;
  logic [NR*ADDR_W-1:0]   rpc = '0;
  logic [ADDR_W-1:0]      pc_o;
  logic                   valid_o;
  logic [1:0]             epoch_o;
  logic                   pend_valid_o;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // behavioural model state
  longint unsigned m_pc;
  bit              m_valid;
  int              m_epoch;
  bit              m_pend;
  int              m_pidx;
  longint unsigned m_ppc;

  pc_redirect_stage #(
    .ADDR_W(32), .NUM_REDIR(3), .RESET_PC(32'h0), .INC(4), .ALIGN_LSB(2), .EPOCH_W(2)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .redir_valid_i(rv), .redir_pc_i(rpc),
    .pc_o(pc_o), .valid_o(valid_o), .epoch_o(epoch_o), .pend_valid_o(pend_valid_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock from the current inputs.
  task automatic model_step();
    int w;
    int ei;
    longint unsigned ep;
    if (rst) begin
      m_pc = 0; m_valid = 0; m_epoch = 0; m_pend = 0; m_pidx = 0; m_ppc = 0;
      return;
    end
    w = -1;
    for (int k = 0; k < NR; k++) if (rv[k] && w < 0) w = k;
    ei = -1; ep = 0;
    if (m_pend && (w < 0 || m_pidx < w)) begin
      ei = m_pidx; ep = m_ppc;
    end else if (w >= 0) begin
      ei = w; ep = (rpc >> (w * ADDR_W)) & 64'hFFFF_FFFC;
    end
    if (stall == 2'b00) begin
      if (ei >= 0) begin
        m_pc = ep; m_valid = 1; m_epoch = (m_epoch + 1) % 4; m_pend = 0;
      end else if (!m_valid) m_valid = 1;
      else m_pc = (m_pc + 4) % 64'h1_0000_0000;
    end else begin
      if (stall == 2'b10) m_valid = 0;
      if (ei >= 0) begin
        m_pend = 1; m_pidx = ei; m_ppc = ep;
      end
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_pc", pc_o, m_pc);
      chk("model_valid", valid_o, m_valid);
      chk("model_epoch", epoch_o, m_epoch);
      chk("model_pend", pend_valid_o, m_pend);
    end
  end

  task automatic cyc(input logic [1:0] s, input logic [2:0] v,
                     input logic [31:0] p0, input logic [31:0] p1, input logic [31:0] p2,
                     input logic r);
    stall = s; rv = v; rpc = {p2, p1, p0}; rst = r;
    @(posedge clk);
    model_step();
    #1;
  endtask

  localparam logic [1:0] PASS = 2'b00, HOLD = 2'b01, BUBB = 2'b10;

  initial begin
    cyc(PASS, 3'b000, 0, 0, 0, 1'b1);
    cyc(PASS, 3'b000, 0, 0, 0, 1'b1);
    chk_en = 1'b1;
    // 1: reset state then sequential fetch
    chk("rst_pc", pc_o, 0); chk("rst_valid", valid_o, 0);
    chk("rst_epoch", epoch_o, 0); chk("rst_pend", pend_valid_o, 0);
    cyc(PASS, 0, 0, 0, 0, 0); chk("t1_pc0", pc_o, 0); chk("t1_v0", valid_o, 1);
    cyc(PASS, 0, 0, 0, 0, 0); chk("t1_pc4", pc_o, 4);
    cyc(PASS, 0, 0, 0, 0, 0); chk("t1_pc8", pc_o, 8); chk("t1_ep", epoch_o, 0);
    // 2: redirect with alignment
    cyc(PASS, 3'b010, 0, 32'h1003, 0, 0); chk("t2_pc", pc_o, 32'h1000); chk("t2_ep", epoch_o, 1);
    cyc(PASS, 0, 0, 0, 0, 0); chk("t2_next", pc_o, 32'h1004);
    // 3: redirects latched during hold, higher priority replaces
    cyc(HOLD, 3'b100, 0, 0, 32'h2000, 0); chk("t3_pend1", pend_valid_o, 1); chk("t3_pc_held", pc_o, 32'h1004);
    cyc(HOLD, 3'b001, 32'h3000, 0, 0, 0); chk("t3_pend2", pend_valid_o, 1);
    cyc(PASS, 0, 0, 0, 0, 0); chk("t3_pc", pc_o, 32'h3000); chk("t3_ep", epoch_o, 2);
    chk("t3_pend0", pend_valid_o, 0);
    // 4: bubble re-issues the same PC
    cyc(PASS, 3'b001, 32'h40, 0, 0, 0); chk("t4_pc", pc_o, 32'h40);
    cyc(BUBB, 0, 0, 0, 0, 0); chk("t4_bv", valid_o, 0); chk("t4_bpc", pc_o, 32'h40);
    cyc(PASS, 0, 0, 0, 0, 0); chk("t4_rv", valid_o, 1); chk("t4_rpc", pc_o, 32'h40);
    cyc(PASS, 0, 0, 0, 0, 0); chk("t4_next", pc_o, 32'h44);
    // 5: pending src0 beats current src1 on Pass
    cyc(HOLD, 3'b001, 32'h500, 0, 0, 0);
    cyc(PASS, 3'b010, 0, 32'h600, 0, 0); chk("t5_pc", pc_o, 32'h500);
    chk("t5_pend", pend_valid_o, 0); chk("t5_ep", epoch_o, 0);
    // 6: reset mid-hold, PC wrap, epoch wrap
    cyc(HOLD, 3'b100, 0, 0, 32'h700, 0); chk("t6_pend", pend_valid_o, 1);
    cyc(HOLD, 3'b000, 0, 0, 0, 1'b1); chk("t6_rpc", pc_o, 0); chk("t6_rpend", pend_valid_o, 0);
    chk("t6_rvalid", valid_o, 0);
    cyc(PASS, 3'b001, 32'hFFFF_FFFC, 0, 0, 0); chk("t6_top", pc_o, 32'hFFFF_FFFC); chk("t6_ep1", epoch_o, 1);
    cyc(PASS, 0, 0, 0, 0, 0); chk("t6_wrap", pc_o, 0);
    cyc(PASS, 3'b100, 0, 0, 32'h10, 0); chk("t6_ep2", epoch_o, 2);
    cyc(PASS, 3'b010, 0, 32'h20, 0, 0); chk("t6_ep3", epoch_o, 3);
    cyc(PASS, 3'b001, 32'h30, 0, 0, 0); chk("t6_ep0", epoch_o, 0); chk("t6_pc30", pc_o, 32'h30);
    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] s;
      logic [2:0] v;
      int r;
      r = $urandom_range(0, 9);
      s = (r < 5) ? PASS : (r < 7) ? HOLD : (r < 9) ? BUBB : 2'b11;
      v = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
      cyc(s, v, $urandom, $urandom, $urandom, ($urandom_range(0, 99) == 0));
    end
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
